// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, reset PC and IF state encodings for the fetch stage
package if_stage_pkg;

   localparam int unsigned PcWidth        = 32;
   localparam int unsigned InstWidth      = 32;
   localparam int unsigned IfToIdBusWidth = PcWidth + InstWidth;
   localparam logic [PcWidth-1:0] IfResetPc = 32'h1bff_fffc;

   typedef enum logic [1:0] {
      IF_EMPTY = 2'd0,
      IF_FRESH = 2'd1,
      IF_HELD  = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_inst_buf.sv
// rtl/if_inst_buf.sv - instruction capture register and FRESH/HELD output mux
// FRESH passes the SRAM read data straight through; HELD replays the buffered copy.
module if_inst_buf
   import if_stage_pkg::*;
#(
   parameter int unsigned INST_W = InstWidth
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INST_W-1:0] rdata_i,
   input  logic              hold_i,
   input  if_state_e         state_i,
   output logic [INST_W-1:0] inst_o
);

   logic [INST_W-1:0] inst_buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_buf_q <= '0;
      end else if (hold_i) begin
         inst_buf_q <= rdata_i;
      end
   end

   assign inst_o = (state_i == IF_HELD) ? inst_buf_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, fetch FSM, PreIF/ID handshake
// Optional misaligned-PC exception (adds if_excp_adef_o) is built when IF_ADEF_EXCP_EN is defined.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IfResetPc,
   parameter int unsigned PC_W     = PcWidth,
   parameter int unsigned INST_W   = InstWidth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   preif_to_if_valid_i,
   input  logic [PC_W-1:0]        preif_pc_i,
   output logic                   if_allowin_o,
   output logic [PC_W-1:0]        pc_o,
   output logic                   inst_sram_en_o,
   output logic [PC_W-1:0]        inst_sram_addr_o,
   input  logic [INST_W-1:0]      inst_sram_rdata_i,
   input  logic                   id_allowin_i,
   input  logic                   br_cancel_i,
   output logic                   if_to_id_valid_o,
   output logic [PC_W+INST_W-1:0] if_to_id_bus_o
`ifdef IF_ADEF_EXCP_EN
   ,
   output logic                   if_excp_adef_o
`endif
);

   if_state_e         state_q;
   logic [PC_W-1:0]   pc_q;
   logic              accept;
   logic              hold;
   logic [INST_W-1:0] inst_raw;
   logic [INST_W-1:0] inst;

   assign if_allowin_o     = (state_q == IF_EMPTY) | br_cancel_i | id_allowin_i;
   assign accept           = preif_to_if_valid_i & if_allowin_o;
   assign hold             = (state_q == IF_FRESH) & ~id_allowin_i & ~br_cancel_i;
   assign if_to_id_valid_o = (state_q != IF_EMPTY) & ~br_cancel_i;
   assign pc_o             = pc_q;
   assign inst_sram_addr_o = preif_pc_i;
   assign if_to_id_bus_o   = {pc_q, inst};

   // A cancel with a simultaneous accept keeps the new (branch target) PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IF_EMPTY;
         pc_q    <= RESET_PC[PC_W-1:0];
      end else if (accept) begin
         state_q <= IF_FRESH;
         pc_q    <= preif_pc_i;
      end else if ((state_q != IF_EMPTY) && (id_allowin_i || br_cancel_i)) begin
         state_q <= IF_EMPTY;
      end else if (state_q == IF_FRESH) begin
         state_q <= IF_HELD;
      end
   end

   if_inst_buf #(.INST_W(INST_W)) u_inst_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdata_i (inst_sram_rdata_i),
      .hold_i  (hold),
      .state_i (state_q),
      .inst_o  (inst_raw)
   );

`ifdef IF_ADEF_EXCP_EN
   logic adef_q;
   logic pc_misaligned;

   assign pc_misaligned = |preif_pc_i[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adef_q <= 1'b0;
      end else if (accept) begin
         adef_q <= pc_misaligned;
      end else if (br_cancel_i || ((state_q != IF_EMPTY) && id_allowin_i)) begin
         adef_q <= 1'b0;
      end
   end

   assign inst_sram_en_o = accept & ~pc_misaligned;
   assign inst           = adef_q ? '0 : inst_raw;
   assign if_excp_adef_o = adef_q & if_to_id_valid_o;
`else
   assign inst_sram_en_o = accept;
   assign inst           = inst_raw;
`endif

endmodule
